// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared constants for the mux vector sequencer
package mux_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_APPLY   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int PI_LSB      = 0;
    localparam int OVR_VAL_LSB = 9;
    localparam int OVR_SEL_LSB = 13;

    localparam int PO_T = 0;
    localparam int PO_N = 1;
    localparam int PO_R = 2;
    localparam int PO_K = 3;
    localparam int PO_M = 4;

endpackage

// File: rtl/mux_vec_buf.sv
// rtl/mux_vec_buf.sv - stimulus/expected vector store and per-vector result array
module mux_vec_buf #(
    parameter int DEPTH  = 8,
    parameter int STIM_W = 17,
    parameter int PO_W   = 5,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [STIM_W-1:0] wr_stim,
    input  logic [PO_W-1:0]   wr_exp,
    input  logic [PO_W-1:0]   wr_mask,
    input  logic [AW-1:0]     vec_addr,
    output logic [STIM_W-1:0] vec_stim,
    output logic [PO_W-1:0]   vec_exp,
    output logic [PO_W-1:0]   vec_mask,
    input  logic              res_clear,
    input  logic              res_en,
    input  logic [AW-1:0]     res_addr,
    input  logic [PO_W-1:0]   res_obs,
    input  logic              res_fail,
    input  logic [AW-1:0]     rb_addr,
    output logic [PO_W-1:0]   rb_obs,
    output logic              rb_fail
);

    logic [STIM_W-1:0] stim_mem [DEPTH];
    logic [PO_W-1:0]   exp_mem  [DEPTH];
    logic [PO_W-1:0]   mask_mem [DEPTH];
    logic [PO_W-1:0]   obs_mem  [DEPTH];
    logic [DEPTH-1:0]  fail_flags;

    // vector entries are only meaningful below count, so they carry no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stim_mem[wr_addr] <= wr_stim;
            exp_mem[wr_addr]  <= wr_exp;
            mask_mem[wr_addr] <= wr_mask;
        end
    end

    // captured outputs, readable after a run
    always_ff @(posedge clk) begin
        if (res_en) begin
            obs_mem[res_addr] <= res_obs;
        end
    end

    // mismatch flags are cleared by reset and by a buffer clear
    always_ff @(posedge clk) begin
        if (rst || res_clear) begin
            fail_flags <= '0;
        end else if (res_en) begin
            fail_flags[res_addr] <= res_fail;
        end
    end

    assign vec_stim = stim_mem[vec_addr];
    assign vec_exp  = exp_mem[vec_addr];
    assign vec_mask = mask_mem[vec_addr];
    assign rb_obs   = obs_mem[rb_addr];
    assign rb_fail  = fail_flags[rb_addr];

endmodule

// File: rtl/mux_vec_sequencer.sv
// rtl/mux_vec_sequencer.sv - applies stored vectors to the mux circuit and checks its outputs
module mux_vec_sequencer #(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2,
    parameter int PI_W   = 9,
    parameter int OVR_W  = 4,
    parameter int PO_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [PI_W+2*OVR_W-1:0]      ld_stim,
    input  logic [PO_W-1:0]              ld_exp,
    input  logic [PO_W-1:0]              ld_mask,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [$clog2(DEPTH+1)-1:0]   fail_cnt,
    output logic [$clog2(DEPTH)-1:0]     first_fail,
    output logic [PI_W-1:0]              dut_pi,
    output logic [OVR_W-1:0]             dut_ovr_val,
    output logic [OVR_W-1:0]             dut_ovr_sel,
    input  logic [PO_W-1:0]              dut_po,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [PO_W-1:0]              rd_obs,
    output logic                         rd_fail
);

    import mux_seq_pkg::*;

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int STIM_W = PI_W + 2 * OVR_W;
    localparam int SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [2:0]        state;
    logic [CW-1:0]     count;
    logic [AW-1:0]     idx;
    logic [SW-1:0]     settle_cnt;
    logic [STIM_W-1:0] cur_stim;
    logic [PO_W-1:0]   cur_exp;
    logic [PO_W-1:0]   cur_mask;
    logic              load_fire;
    logic              cap_fail;
    logic              last_vec;
    logic              in_idle;

    assign in_idle   = (state == ST_IDLE);
    assign ld_ready  = in_idle && (count < CW'(DEPTH));
    assign load_fire = ld_valid && ld_ready && !clear;
    assign busy      = !in_idle;
    assign cap_fail  = |((dut_po ^ cur_exp) & cur_mask);
    assign last_vec  = (CW'(idx) == (count - CW'(1)));

    mux_vec_buf #(
        .DEPTH  (DEPTH),
        .STIM_W (STIM_W),
        .PO_W   (PO_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (load_fire),
        .wr_addr   (count[AW-1:0]),
        .wr_stim   (ld_stim),
        .wr_exp    (ld_exp),
        .wr_mask   (ld_mask),
        .vec_addr  (idx),
        .vec_stim  (cur_stim),
        .vec_exp   (cur_exp),
        .vec_mask  (cur_mask),
        .res_clear (in_idle && clear),
        .res_en    (state == ST_CAPTURE),
        .res_addr  (idx),
        .res_obs   (dut_po),
        .res_fail  (cap_fail),
        .rb_addr   (rd_idx),
        .rb_obs    (rd_obs),
        .rb_fail   (rd_fail)
    );

    // run sequencing: load/clear/start in IDLE, then apply-settle-capture per vector
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            idx         <= '0;
            settle_cnt  <= '0;
            fail_cnt    <= '0;
            first_fail  <= '0;
            pass        <= 1'b0;
            done        <= 1'b0;
            dut_pi      <= '0;
            dut_ovr_val <= '0;
            dut_ovr_sel <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        count      <= '0;
                        fail_cnt   <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                    end else begin
                        if (load_fire) begin
                            count <= count + CW'(1);
                        end
                        if (start) begin
                            fail_cnt   <= '0;
                            first_fail <= '0;
                            idx        <= '0;
                            // an entry accepted alongside start joins this run
                            if ((count != '0) || load_fire) begin
                                pass  <= 1'b0;
                                state <= ST_APPLY;
                            end else begin
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_APPLY: begin
                    dut_pi      <= cur_stim[PI_LSB +: PI_W];
                    dut_ovr_val <= cur_stim[OVR_VAL_LSB +: OVR_W];
                    dut_ovr_sel <= cur_stim[OVR_SEL_LSB +: OVR_W];
                    settle_cnt  <= SW'(SETTLE - 1);
                    state       <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (cap_fail) begin
                        fail_cnt <= fail_cnt + CW'(1);
                        if (fail_cnt == '0) begin
                            first_fail <= idx;
                        end
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    done        <= 1'b1;
                    pass        <= (fail_cnt == '0);
                    dut_pi      <= '0;
                    dut_ovr_val <= '0;
                    dut_ovr_sel <= '0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
